// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt/exception sequencer: MSR bit positions,
// vector offsets, SPR select codes, FSM and cause encodings.
package int_ctrl_pkg;

  // Architected bit numbers are big-endian (bit 0 = MSB of a 32-bit word).
  function automatic int be_bit(input int n);
    return 31 - n;
  endfunction

  localparam int MSR_EE = be_bit(16);
  localparam int MSR_PR = be_bit(17);
  localparam int MSR_IP = be_bit(25);

  localparam int VEC_W = 12;
  localparam logic [VEC_W-1:0] INT_VEC_EXT  = 12'h500;
  localparam logic [VEC_W-1:0] INT_VEC_PROG = 12'h700;
  localparam logic [VEC_W-1:0] INT_VEC_DEC  = 12'h900;
  localparam logic [VEC_W-1:0] INT_VEC_SC   = 12'hC00;

  localparam logic [1:0] SPR_SEL_SRR0 = 2'b00;
  localparam logic [1:0] SPR_SEL_SRR1 = 2'b01;
  localparam logic [1:0] SPR_SEL_MSR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TAKE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_PROG = 2'd0,
    CAUSE_SC   = 2'd1,
    CAUSE_EXT  = 2'd2,
    CAUSE_DEC  = 2'd3
  } cause_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Core-side signal bundle of the interrupt sequencer: event inputs, SPR write
// port, next-PC outputs, register read-back and FSM debug state.
interface int_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  import int_ctrl_pkg::*;

  // Handshake: prog_exc/sc_exc/rfi_valid/spr_we are one-cycle qualifiers with
  // no ready; they act only if high in a cycle the sequencer can accept them
  // (otherwise dropped). ext_int is a level, dec_int is latched as pending.
  logic                ext_int;
  logic                dec_int;
  logic                prog_exc;
  logic                sc_exc;
  logic [PC_WIDTH-1:0] exc_pc;
  logic                rfi_valid;
  logic                pipe_empty;
  logic                spr_we;
  logic [1:0]          spr_sel;
  logic [PC_WIDTH-1:0] spr_wd;

  logic                int_flush;
  logic                int_take;
  logic [PC_WIDTH-1:0] intAddr;
  logic [PC_WIDTH-1:0] SRR0rd;
  logic [PC_WIDTH-1:0] SRR1rd;
  logic [PC_WIDTH-1:0] MSRrd;
  logic                rfi_ack;
  state_t              dbg_state;

  modport master (
    output ext_int, dec_int, prog_exc, sc_exc, exc_pc, rfi_valid, pipe_empty,
           spr_we, spr_sel, spr_wd,
    input  int_flush, int_take, intAddr, SRR0rd, SRR1rd, MSRrd, rfi_ack,
           dbg_state
  );

  modport slave (
    input  ext_int, dec_int, prog_exc, sc_exc, exc_pc, rfi_valid, pipe_empty,
           spr_we, spr_sel, spr_wd,
    output int_flush, int_take, intAddr, SRR0rd, SRR1rd, MSRrd, rfi_ack,
           dbg_state
  );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational cause arbiter: picks the highest-priority enabled cause and
// returns its vector offset. Async causes are masked by MSR[EE].
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic             prog,
  input  logic             sc,
  input  logic             ext,
  input  logic             dec,
  input  logic             ee,
  output logic             valid,
  output cause_t           cause,
  output logic [VEC_W-1:0] vec
);

  always_comb begin
    valid = 1'b0;
    cause = CAUSE_PROG;
    vec   = '0;
    if (prog) begin
      valid = 1'b1;
      cause = CAUSE_PROG;
      vec   = INT_VEC_PROG;
    end else if (sc) begin
      valid = 1'b1;
      cause = CAUSE_SC;
      vec   = INT_VEC_SC;
    end else if (ext && ee) begin
      valid = 1'b1;
      cause = CAUSE_EXT;
      vec   = INT_VEC_EXT;
    end else if (dec && ee) begin
      valid = 1'b1;
      cause = CAUSE_DEC;
      vec   = INT_VEC_DEC;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception sequencer: arbitrates causes, drains the pipe, issues
// the vector and saves/restores MSR via SRR0/SRR1; also executes rfi.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] VEC_BASE_HI = 32'hFFF0_0000,
  parameter logic [PC_WIDTH-1:0] MSR_RST     = 32'h0000_0040
) (
  input  logic       clk,
  input  logic       rst_n,
  int_ctrl_if.slave  bus
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] msr_q, srr0_q, srr1_q;
  logic [PC_WIDTH-1:0] save_pc_q, int_addr_q;
  logic [VEC_W-1:0]    cause_vec_q;
  logic                cause_dec_q;
  logic                dec_pend_q;

  logic                cause_valid;
  cause_t              cause_sel;
  logic [VEC_W-1:0]    cause_vec;
  logic                accept;
  logic                rfi_go;
  logic                take_end;
  logic [PC_WIDTH-1:0] msr_taken;

  int_prio_enc u_prio (
    .prog  (bus.prog_exc),
    .sc    (bus.sc_exc),
    .ext   (bus.ext_int),
    .dec   (dec_pend_q),
    .ee    (msr_q[MSR_EE]),
    .valid (cause_valid),
    .cause (cause_sel),
    .vec   (cause_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // An accepted cause always beats a same-cycle rfi; the rfi is flushed.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rfi_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cause_valid) begin
          accept  = 1'b1;
          state_d = ST_DRAIN;
        end else if (bus.rfi_valid) begin
          rfi_go = 1'b1;
        end
      end
      ST_DRAIN: if (bus.pipe_empty) state_d = ST_TAKE;
      ST_TAKE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign take_end = (state_q == ST_TAKE);

  always_comb begin
    msr_taken         = msr_q;
    msr_taken[MSR_EE] = 1'b0;
    msr_taken[MSR_PR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      save_pc_q   <= '0;
      cause_vec_q <= '0;
      cause_dec_q <= 1'b0;
    end else if (accept) begin
      save_pc_q   <= (cause_sel == CAUSE_SC) ? bus.exc_pc + PC_WIDTH'(4) : bus.exc_pc;
      cause_vec_q <= cause_vec;
      cause_dec_q <= (cause_sel == CAUSE_DEC);
    end
  end

  // Vector base is chosen by MSR[IP] as it stands when the drain completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_addr_q <= '0;
    end else if (state_q == ST_DRAIN && bus.pipe_empty) begin
      int_addr_q <= (msr_q[MSR_IP] ? VEC_BASE_HI : '0)
                  | {{(PC_WIDTH-VEC_W){1'b0}}, cause_vec_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        dec_pend_q <= 1'b0;
    else if (bus.dec_int)              dec_pend_q <= 1'b1;
    else if (take_end && cause_dec_q)  dec_pend_q <= 1'b0;
  end

  // Priority on the architected registers: take > rfi restore > mtspr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msr_q  <= MSR_RST;
      srr0_q <= '0;
      srr1_q <= '0;
    end else if (take_end) begin
      srr0_q <= save_pc_q;
      srr1_q <= msr_q;
      msr_q  <= msr_taken;
    end else begin
      if (bus.spr_we) begin
        case (bus.spr_sel)
          SPR_SEL_SRR0: srr0_q <= bus.spr_wd;
          SPR_SEL_SRR1: srr1_q <= bus.spr_wd;
          SPR_SEL_MSR:  msr_q  <= bus.spr_wd;
          default: ;
        endcase
      end
      if (rfi_go) msr_q <= srr1_q;
    end
  end

  assign bus.int_flush = (state_q == ST_DRAIN) || (state_q == ST_TAKE);
  assign bus.int_take  = take_end;
  assign bus.intAddr   = int_addr_q;
  assign bus.SRR0rd    = srr0_q;
  assign bus.SRR1rd    = srr1_q;
  assign bus.MSRrd     = msr_q;
  assign bus.rfi_ack   = rfi_go;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand sequences for multi-cycle
// corners, and random traffic checked every cycle against a behavioural model.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam logic hi = 1'b1;
  localparam logic lo = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_ctrl_if #(.PC_WIDTH(32)) bus ();

  int_ctrl #(
    .PC_WIDTH    (32),
    .VEC_BASE_HI (32'hFFF0_0000),
    .MSR_RST     (32'h0000_0040)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architected bits in little-endian terms: EE=MSR[16] -> 1<<15, PR=MSR[17]
  // -> 1<<14, IP=MSR[25] -> 1<<6.
  localparam logic [31:0] M_EE = 32'h0000_8000;
  localparam logic [31:0] M_PR = 32'h0000_4000;
  localparam logic [31:0] M_IP = 32'h0000_0040;

  logic [31:0] m_msr, m_srr0, m_srr1, m_addr, m_save, m_vec;
  bit          m_busy, m_vectoring, m_dec, m_vec_is_dec;
  logic [31:0] vec_tab [4];

  task automatic model_reset();
    m_msr = 32'h40; m_srr0 = '0; m_srr1 = '0; m_addr = '0; m_save = '0; m_vec = '0;
    m_busy = 0; m_vectoring = 0; m_dec = 0; m_vec_is_dec = 0;
  endtask

  // Index into vec_tab of the cause that wins this cycle, -1 if none.
  function automatic int model_cause();
    bit ee = (m_msr & M_EE) != 0;
    if (bus.prog_exc)            return 0;
    if (bus.sc_exc)              return 1;
    if (bus.ext_int && ee)       return 2;
    if (m_dec && ee)             return 3;
    return -1;
  endfunction

  task automatic model_check();
    int c = model_cause();
    bit exp_ack = !m_busy && (c < 0) && bus.rfi_valid;
    check("m_flush", 32'(bus.int_flush), 32'(m_busy));
    check("m_take",  32'(bus.int_take),  32'(m_busy && m_vectoring));
    check("m_ack",   32'(bus.rfi_ack),   32'(exp_ack));
    check("m_addr",  bus.intAddr, m_addr);
    check("m_srr0",  bus.SRR0rd,  m_srr0);
    check("m_srr1",  bus.SRR1rd,  m_srr1);
    check("m_msr",   bus.MSRrd,   m_msr);
  endtask

  task automatic model_step();
    int c = model_cause();
    logic [31:0] n_msr = m_msr, n_srr0 = m_srr0, n_srr1 = m_srr1;
    bit clr = 0;
    if (!(m_busy && m_vectoring) && bus.spr_we) begin
      case (bus.spr_sel)
        2'd0: n_srr0 = bus.spr_wd;
        2'd1: n_srr1 = bus.spr_wd;
        2'd2: n_msr  = bus.spr_wd;
        default: ;
      endcase
    end
    if (!m_busy) begin
      if (c >= 0) begin
        m_busy = 1; m_vectoring = 0;
        m_vec = vec_tab[c];
        m_save = (c == 1) ? bus.exc_pc + 32'd4 : bus.exc_pc;
        m_vec_is_dec = (c == 3);
      end else if (bus.rfi_valid) begin
        n_msr = m_srr1;
      end
    end else if (!m_vectoring) begin
      if (bus.pipe_empty) begin
        m_vectoring = 1;
        m_addr = (((m_msr & M_IP) != 0) ? 32'hFFF0_0000 : 32'h0) | m_vec;
      end
    end else begin
      m_busy = 0; m_vectoring = 0;
      n_srr0 = m_save; n_srr1 = m_msr; n_msr = m_msr & ~(M_EE | M_PR);
      clr = m_vec_is_dec;
    end
    m_dec = bus.dec_int ? 1'b1 : (clr ? 1'b0 : m_dec);
    m_msr = n_msr; m_srr0 = n_srr0; m_srr1 = n_srr1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ext, input logic dec, input logic prog, input logic sc,
                       input logic [31:0] pc, input logic rfi, input logic pe,
                       input logic we, input logic [1:0] sel, input logic [31:0] wd);
    bus.ext_int = ext; bus.dec_int = dec; bus.prog_exc = prog; bus.sc_exc = sc;
    bus.exc_pc = pc; bus.rfi_valid = rfi; bus.pipe_empty = pe;
    bus.spr_we = we; bus.spr_sel = sel; bus.spr_wd = wd;
  endtask

  task automatic idle(input logic pe);
    drive(lo, lo, lo, lo, 32'h0, lo, pe, lo, 2'b00, 32'h0);
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flush"}, 32'(bus.int_flush), 32'h0);
    check({tag, "_take"},  32'(bus.int_take),  32'h0);
    check({tag, "_ack"},   32'(bus.rfi_ack),   32'h0);
    check({tag, "_addr"},  bus.intAddr, 32'h0);
    check({tag, "_msr"},   bus.MSRrd,   32'h40);
    check({tag, "_srr0"},  bus.SRR0rd,  32'h0);
    check({tag, "_srr1"},  bus.SRR1rd,  32'h0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ext, dec, prog, sc;
    logic [31:0] pc;
    logic        rfi, pe, we;
    logic [1:0]  sel;
    logic [31:0] wd;
    logic        flush, take, ack;
    logic [31:0] addr, srr0, srr1, msr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int drain_cnt;
    vec_tab[0] = 32'h700; vec_tab[1] = 32'hC00; vec_tab[2] = 32'h500; vec_tab[3] = 32'h900;

    //          ext dec prog sc   pc          rfi pe  we  sel    wd            flush take ack addr            srr0      srr1      msr
    tbl[0]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, hi, 2'b10, 32'h8040,     lo, lo, lo, 32'h0,          32'h0,   32'h0,    32'h40};
    tbl[1]  = '{lo, lo, lo, hi, 32'h100,    lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'h0,          32'h0,   32'h0,    32'h8040};
    tbl[2]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, lo, lo, 32'h0,          32'h0,   32'h0,    32'h8040};
    tbl[3]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, hi, lo, 32'hFFF0_0C00,  32'h0,   32'h0,    32'h8040};
    tbl[4]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h40};
    tbl[5]  = '{lo, lo, lo, lo, 32'h0,      hi, hi, lo, 2'b00, 32'h0,        lo, lo, hi, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h40};
    tbl[6]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h8040};
    tbl[7]  = '{lo, lo, lo, hi, 32'h200,    hi, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h8040};
    tbl[8]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, lo, lo, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h8040};
    tbl[9]  = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, hi, lo, 32'hFFF0_0C00,  32'h104, 32'h8040, 32'h8040};
    tbl[10] = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'hFFF0_0C00,  32'h204, 32'h8040, 32'h40};
    tbl[11] = '{lo, lo, lo, lo, 32'h0,      lo, hi, hi, 2'b10, 32'h8000,     lo, lo, lo, 32'hFFF0_0C00,  32'h204, 32'h8040, 32'h40};
    tbl[12] = '{hi, lo, lo, lo, 32'h300,    lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'hFFF0_0C00,  32'h204, 32'h8040, 32'h8000};
    tbl[13] = '{hi, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, lo, lo, 32'hFFF0_0C00,  32'h204, 32'h8040, 32'h8000};
    tbl[14] = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        hi, hi, lo, 32'h0000_0500,  32'h204, 32'h8040, 32'h8000};
    tbl[15] = '{lo, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'h0000_0500,  32'h300, 32'h8000, 32'h0};
    tbl[16] = '{hi, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'h0000_0500,  32'h300, 32'h8000, 32'h0};
    tbl[17] = '{hi, lo, lo, lo, 32'h0,      lo, hi, hi, 2'b11, 32'hFFFF_FFFF, lo, lo, lo, 32'h0000_0500,  32'h300, 32'h8000, 32'h0};
    tbl[18] = '{hi, lo, lo, lo, 32'h0,      lo, hi, lo, 2'b00, 32'h0,        lo, lo, lo, 32'h0000_0500,  32'h300, 32'h8000, 32'h0};

    // Power-on reset
    idle(hi);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].ext, tbl[i].dec, tbl[i].prog, tbl[i].sc, tbl[i].pc, tbl[i].rfi,
            tbl[i].pe, tbl[i].we, tbl[i].sel, tbl[i].wd);
      sample();
      check($sformatf("tbl%0d_flush", i), 32'(bus.int_flush), 32'(tbl[i].flush));
      check($sformatf("tbl%0d_take", i),  32'(bus.int_take),  32'(tbl[i].take));
      check($sformatf("tbl%0d_ack", i),   32'(bus.rfi_ack),   32'(tbl[i].ack));
      check($sformatf("tbl%0d_addr", i),  bus.intAddr, tbl[i].addr);
      check($sformatf("tbl%0d_srr0", i),  bus.SRR0rd,  tbl[i].srr0);
      check($sformatf("tbl%0d_srr1", i),  bus.SRR1rd,  tbl[i].srr1);
      check($sformatf("tbl%0d_msr", i),   bus.MSRrd,   tbl[i].msr);
      advance();
    end

    // prog and ext together: prog wins, ext follows the rfi that restores EE
    drive(lo, lo, lo, lo, 32'h0, lo, hi, hi, 2'b10, 32'h8040); sample(); advance();
    drive(hi, lo, hi, lo, 32'h400, lo, hi, lo, 2'b00, 32'h0); sample();
    check("pe_accept_flush", 32'(bus.int_flush), 32'h0); advance();
    drive(hi, lo, lo, lo, 32'h0, lo, hi, lo, 2'b00, 32'h0); sample();
    check("pe_drain_flush", 32'(bus.int_flush), 32'h1);
    check("pe_drain_take", 32'(bus.int_take), 32'h0); advance();
    sample();
    check("pe_take", 32'(bus.int_take), 32'h1);
    check("pe_addr", bus.intAddr, 32'hFFF0_0700); advance();
    sample();
    check("pe_noflush_ee0", 32'(bus.int_flush), 32'h0);
    check("pe_srr0", bus.SRR0rd, 32'h400);
    check("pe_srr1", bus.SRR1rd, 32'h8040);
    check("pe_msr", bus.MSRrd, 32'h40); advance();
    drive(hi, lo, lo, lo, 32'h0, hi, hi, lo, 2'b00, 32'h0); sample();
    check("pe_rfi_ack", 32'(bus.rfi_ack), 32'h1); advance();
    drive(hi, lo, lo, lo, 32'h480, lo, hi, lo, 2'b00, 32'h0); sample();
    check("pe_rfi_msr", bus.MSRrd, 32'h8040);
    check("pe_rfi_ack_gone", 32'(bus.rfi_ack), 32'h0); advance();
    idle(hi); sample();
    check("pe_ext_flush", 32'(bus.int_flush), 32'h1); advance();
    sample();
    check("pe_ext_take", 32'(bus.int_take), 32'h1);
    check("pe_ext_addr", bus.intAddr, 32'hFFF0_0500); advance();
    sample();
    check("pe_ext_srr0", bus.SRR0rd, 32'h480); advance();

    // dec pulse while draining a held pipe
    drive(lo, lo, lo, lo, 32'h0, lo, hi, hi, 2'b10, 32'h8040); sample(); advance();
    drive(lo, lo, lo, hi, 32'h500, lo, lo, lo, 2'b00, 32'h0); sample(); advance();
    drain_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(lo, (i == 0) ? hi : lo, lo, lo, 32'h0, lo, (i == 4) ? hi : lo, lo, 2'b00, 32'h0);
      sample();
      if (bus.int_flush && !bus.int_take) drain_cnt++;
      advance();
    end
    idle(hi); sample();
    check("dd_drain_cycles", 32'(drain_cnt), 32'd5);
    check("dd_sc_take", 32'(bus.int_take), 32'h1);
    check("dd_sc_addr", bus.intAddr, 32'hFFF0_0C00); advance();
    for (int i = 0; i < 3; i++) begin
      sample(); check("dd_masked", 32'(bus.int_flush), 32'h0); advance();
    end
    drive(lo, lo, lo, lo, 32'h0, hi, hi, lo, 2'b00, 32'h0); sample();
    check("dd_rfi_ack", 32'(bus.rfi_ack), 32'h1); advance();
    idle(hi); sample(); advance();
    sample(); check("dd_dec_flush", 32'(bus.int_flush), 32'h1); advance();
    sample();
    check("dd_dec_take", 32'(bus.int_take), 32'h1);
    check("dd_dec_addr", bus.intAddr, 32'hFFF0_0900); advance();
    drive(lo, lo, lo, lo, 32'h0, hi, hi, lo, 2'b00, 32'h0); sample();
    check("dd_rfi2_ack", 32'(bus.rfi_ack), 32'h1); advance();
    idle(hi);
    for (int i = 0; i < 3; i++) begin
      sample(); check("dd_pend_cleared", 32'(bus.int_flush), 32'h0); advance();
    end

    // async reset in the middle of a drain
    drive(lo, lo, lo, hi, 32'h600, lo, lo, lo, 2'b00, 32'h0); sample(); advance();
    idle(lo);
    check("rst_pre_flush", 32'(bus.int_flush), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] wd;
      case ($urandom_range(0, 4))
        0: wd = 32'h8040;
        1: wd = 32'h8000;
        2: wd = 32'h0040;
        3: wd = 32'hC040;
        default: wd = $urandom;
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), wd);
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
